multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; all encodings are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instr[31:26] from instruction register.
REQ-005 funct  input  6  instr[5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  shared memory completes current access this cycle.
REQ-008 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 memwrite  output  1  memory write strobe.
REQ-010 irwrite  output  1  instruction register load enable.
REQ-011 regdst  output  1  write register select: 0=rt, 1=rd.
REQ-012 memtoreg  output  1  writeback select: 0=ALUOut, 1=memory data.
REQ-013 regwrite  output  1  register file write enable.
REQ-014 alusrca  output  1  ALU A: 0=PC, 1=register A.
REQ-015 alusrcb  output  2  ALU B: 00=reg B, 01=constant 4, 10=signimm, 11=signimm<<2.
REQ-016 pcsrc  output  2  PC next: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-017 alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-018 pcen  output  1  PC load enable.
REQ-019 illegal_op  output  1  one-cycle pulse on unsupported opcode/funct.
REQ-020 state  output  4  current state encoding, for debug.

Function
REQ-021 SHALL be a Moore FSM: registered state; outputs decoded from state, except pcen, irwrite and memwrite, which also depend on zero/mem_ready as specified below.
REQ-022 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; every output not listed for a state SHALL be 0.
REQ-023 FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00; irwrite=pcwrite=mem_ready; stay while mem_ready=0, go to DECODE when mem_ready=1.
REQ-024 DECODE: alusrca=0, alusrcb=11, add; next state by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->FETCH with illegal_op=1.
REQ-025 MEMADR: alusrca=1, alusrcb=10, add; lw->MEMRD, sw->MEMWR.
REQ-026 MEMRD: iord=1; hold until mem_ready=1, then MEMWB.
REQ-027 MEMWB: regdst=0, memtoreg=1, regwrite=1; ->FETCH.
REQ-028 MEMWR: iord=1, memwrite=1 held until mem_ready=1, then FETCH.
REQ-029 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); ->ALUWB.
REQ-030 Unsupported funct in EXECUTE SHALL drive alucontrol=010, pulse illegal_op, and go to FETCH (no ALUWB, no register write).
REQ-031 ALUWB: regdst=1, memtoreg=0, regwrite=1; ->FETCH.
REQ-032 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1; ->FETCH.
REQ-033 ADDIEX: alusrca=1, alusrcb=10, add; ->ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; ->FETCH.
REQ-034 JUMP: pcsrc=10, pcwrite=1; ->FETCH.
REQ-035 pcen SHALL equal pcwrite OR (branch AND zero), combinationally.
REQ-036 Zero-wait latencies (mem_ready=1 throughout): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-037 reset=1 SHALL force state to FETCH asynchronously.
REQ-038 While reset=1, all outputs except state SHALL be 0; state SHALL read FETCH.
REQ-039 Reset asserted mid-instruction SHALL abandon it with no further regwrite, memwrite or pcen.

Structure
REQ-040 Package mips_ctrl_pkg SHALL hold the state enum, opcode and funct constants, and alucontrol/aluop encodings.
REQ-041 ALU decode (aluop + funct -> alucontrol, illegal funct flag) SHALL be sub-module alu_decoder.

Verification
REQ-042 lw, op=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1 only in cycle 5.
REQ-043 sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; regwrite never 1.
REQ-044 beq, zero=1 -> pcen=1 in BRANCH with pcsrc=01; zero=0 -> pcen=0 in BRANCH.
REQ-045 R-type funct=101010 -> alucontrol=111 in EXECUTE, regdst=1 in ALUWB; funct=111111 -> illegal_op pulse, next FETCH, no regwrite.
REQ-046 op=111111 -> illegal_op=1 in DECODE for one cycle, next state FETCH.
REQ-047 reset asserted in MEMWB between clock edges -> state=FETCH and regwrite=0 immediately, before the next edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// fields, ALU operation selects and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  // How the ALU decoder picks its operation: fixed add/sub, or from funct.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller (master) and the datapath/memory
// side (slave): instruction fields and status in, control strobes and selects out.
interface multicycle_control_if;

  // Memory handshake: the controller presents an access (FETCH read, MEMRD read,
  // MEMWR write with memwrite=1) and holds it unchanged every cycle; the access
  // completes in the cycle mem_ready=1 and the controller advances on that edge.
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       pcen;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal_op, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal_op, state
  );

endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's ALU operation select plus the R-type funct field to the
// 3-bit ALU control, flagging funct codes the datapath does not implement.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal_funct
);

  always_comb begin
    alucontrol    = ALUCTL_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUCTL_ADD;
      ALUOP_SUB: alucontrol = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALUCTL_ADD;
          FUNCT_SUB: alucontrol = ALUCTL_SUB;
          FUNCT_AND: alucontrol = ALUCTL_AND;
          FUNCT_OR:  alucontrol = ALUCTL_OR;
          FUNCT_SLT: alucontrol = ALUCTL_SLT;
          // Unknown funct keeps a harmless add on the ALU while flagged.
          default:   illegal_funct = 1'b1;
        endcase
      end
      default: alucontrol = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multicycle MIPS controller (lw, sw, R-type, beq, addi, j) with a
// shared memory that may stall via mem_ready.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e     state_q;
  state_e     state_d;

  aluop_e     aluop_c;
  logic [2:0] dec_alucontrol;
  logic       dec_illegal_funct;

  logic       iord_c;
  logic       memwrite_c;
  logic       irwrite_c;
  logic       regdst_c;
  logic       memtoreg_c;
  logic       regwrite_c;
  logic       alusrca_c;
  logic [1:0] alusrcb_c;
  logic [1:0] pcsrc_c;
  logic       alu_en_c;
  logic       pcwrite_c;
  logic       branch_c;
  logic       illegal_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Kept apart from the main decode so the decoder output feeding the
  // next-state logic does not form a combinational loop through aluop.
  always_comb begin
    aluop_c = ALUOP_ADD;
    if (state_q == S_EXECUTE)     aluop_c = ALUOP_FUNCT;
    else if (state_q == S_BRANCH) aluop_c = ALUOP_SUB;
  end

  alu_decoder u_alu_decoder (
    .aluop         (aluop_c),
    .funct         (bus.funct),
    .alucontrol    (dec_alucontrol),
    .illegal_funct (dec_illegal_funct)
  );

  always_comb begin
    state_d    = state_q;
    iord_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = ALUSRCB_REG;
    pcsrc_c    = PCSRC_ALU;
    alu_en_c   = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_c = ALUSRCB_FOUR;
        alu_en_c  = 1'b1;
        irwrite_c = bus.mem_ready;
        pcwrite_c = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_c = ALUSRCB_IMMSH2;
        alu_en_c  = 1'b1;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = ALUSRCB_IMM;
        alu_en_c  = 1'b1;
        state_d   = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca_c = 1'b1;
        alu_en_c  = 1'b1;
        if (dec_illegal_funct) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d   = S_ALUWB;
        end
      end
      S_ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c = 1'b1;
        alu_en_c  = 1'b1;
        pcsrc_c   = PCSRC_ALUOUT;
        branch_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = ALUSRCB_IMM;
        alu_en_c  = 1'b1;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_c   = PCSRC_JUMP;
        pcwrite_c = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every strobe combinationally, so an abandoned instruction
  // cannot write anything even before the next clock edge.
  assign bus.iord       = ~reset & iord_c;
  assign bus.memwrite   = ~reset & memwrite_c;
  assign bus.irwrite    = ~reset & irwrite_c;
  assign bus.regdst     = ~reset & regdst_c;
  assign bus.memtoreg   = ~reset & memtoreg_c;
  assign bus.regwrite   = ~reset & regwrite_c;
  assign bus.alusrca    = ~reset & alusrca_c;
  assign bus.alusrcb    = reset ? 2'b00 : alusrcb_c;
  assign bus.pcsrc      = reset ? 2'b00 : pcsrc_c;
  assign bus.alucontrol = (reset || !alu_en_c) ? 3'b000 : dec_alucontrol;
  assign bus.pcen       = ~reset & (pcwrite_c | (branch_c & bus.zero));
  assign bus.illegal_op = ~reset & illegal_c;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a cycle-by-cycle vector table of
// instruction sequences, plus hand sequences for reset taken mid-instruction.
module tb_multicycle_control;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD = 4'd3,  ST_MEMWB = 4'd4,   ST_MEMWR = 4'd5;
  localparam logic [3:0] ST_EXEC = 4'd6,   ST_ALUWB = 4'd7,   ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_BAD = 6'b111111;

  // Control word: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
  // alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], pcen, illegal_op.
  localparam logic [15:0] C_ZERO       = 16'b0_0_0_0_0_0_0_00_00_000_0_0;
  localparam logic [15:0] C_FETCH_RDY  = 16'b0_0_1_0_0_0_0_01_00_010_1_0;
  localparam logic [15:0] C_FETCH_WAIT = 16'b0_0_0_0_0_0_0_01_00_010_0_0;
  localparam logic [15:0] C_DECODE     = 16'b0_0_0_0_0_0_0_11_00_010_0_0;
  localparam logic [15:0] C_DECODE_ILL = 16'b0_0_0_0_0_0_0_11_00_010_0_1;
  localparam logic [15:0] C_MEMADR     = 16'b0_0_0_0_0_0_1_10_00_010_0_0;
  localparam logic [15:0] C_MEMRD      = 16'b1_0_0_0_0_0_0_00_00_000_0_0;
  localparam logic [15:0] C_MEMWB      = 16'b0_0_0_0_1_1_0_00_00_000_0_0;
  localparam logic [15:0] C_MEMWR      = 16'b1_1_0_0_0_0_0_00_00_000_0_0;
  localparam logic [15:0] C_EX_ADD     = 16'b0_0_0_0_0_0_1_00_00_010_0_0;
  localparam logic [15:0] C_EX_SUB     = 16'b0_0_0_0_0_0_1_00_00_110_0_0;
  localparam logic [15:0] C_EX_AND     = 16'b0_0_0_0_0_0_1_00_00_000_0_0;
  localparam logic [15:0] C_EX_OR      = 16'b0_0_0_0_0_0_1_00_00_001_0_0;
  localparam logic [15:0] C_EX_SLT     = 16'b0_0_0_0_0_0_1_00_00_111_0_0;
  localparam logic [15:0] C_EX_ILL     = 16'b0_0_0_0_0_0_1_00_00_010_0_1;
  localparam logic [15:0] C_ALUWB      = 16'b0_0_0_1_0_1_0_00_00_000_0_0;
  localparam logic [15:0] C_BR_TAKEN   = 16'b0_0_0_0_0_0_1_00_01_110_1_0;
  localparam logic [15:0] C_BR_NOT     = 16'b0_0_0_0_0_0_1_00_01_110_0_0;
  localparam logic [15:0] C_ADDIEX     = 16'b0_0_0_0_0_0_1_10_00_010_0_0;
  localparam logic [15:0] C_ADDIWB     = 16'b0_0_0_0_0_1_0_00_00_000_0_0;
  localparam logic [15:0] C_JUMP       = 16'b0_0_0_0_0_0_0_00_10_000_1_0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] ctl_act;
  assign ctl_act = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                    bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc,
                    bus.alucontrol, bus.pcen, bus.illegal_op};

  function automatic void add(string name, logic [5:0] op, logic [5:0] funct,
                              logic zero, logic mr, logic [3:0] st, logic [15:0] ctl);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.zero = zero; v.mr = mr;
    v.exp_state = st; v.exp_ctl = ctl;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic [5:0] op, logic [5:0] funct, logic zero, logic mr);
    bus.op = op; bus.funct = funct; bus.zero = zero; bus.mem_ready = mr;
  endtask

  task automatic check(string name, logic [3:0] exp_state, logic [15:0] exp_ctl);
    checks++;
    if (bus.state !== exp_state || ctl_act !== exp_ctl) begin
      errors++;
      $display("FAIL %s: state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, bus.state, ctl_act, exp_state, exp_ctl);
    end
  endtask

  // Called at a falling edge: drive, let logic settle, compare, run one clock.
  task automatic apply(vec_t v);
    drive(v.op, v.funct, v.zero, v.mr);
    #1;
    check(v.name, v.exp_state, v.exp_ctl);
    @(negedge clk);
  endtask

  task automatic step(string name, logic [5:0] op, logic [5:0] funct, logic zero,
                      logic mr, logic [3:0] st, logic [15:0] ctl);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.zero = zero; v.mr = mr;
    v.exp_state = st; v.exp_ctl = ctl;
    apply(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add("lw_fetch",   OP_LW, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("lw_decode",  OP_LW, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("lw_memadr",  OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMADR, C_MEMADR);
    add("lw_memrd",   OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMRD,  C_MEMRD);
    add("lw_memwb",   OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMWB,  C_MEMWB);
    add("sw_fetch",   OP_SW, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("sw_decode",  OP_SW, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("sw_memadr",  OP_SW, 6'd0, 1'b0, 1'b1, ST_MEMADR, C_MEMADR);
    add("sw_wait1",   OP_SW, 6'd0, 1'b0, 1'b0, ST_MEMWR,  C_MEMWR);
    add("sw_wait2",   OP_SW, 6'd0, 1'b0, 1'b0, ST_MEMWR,  C_MEMWR);
    add("sw_wait3",   OP_SW, 6'd0, 1'b0, 1'b0, ST_MEMWR,  C_MEMWR);
    add("sw_done",    OP_SW, 6'd0, 1'b0, 1'b1, ST_MEMWR,  C_MEMWR);
    add("slt_fwait",  OP_R, F_SLT, 1'b0, 1'b0, ST_FETCH,  C_FETCH_WAIT);
    add("slt_fetch",  OP_R, F_SLT, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("slt_decode", OP_R, F_SLT, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("slt_exec",   OP_R, F_SLT, 1'b0, 1'b1, ST_EXEC,   C_EX_SLT);
    add("slt_aluwb",  OP_R, F_SLT, 1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
    add("add_fetch",  OP_R, F_ADD, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("add_decode", OP_R, F_ADD, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("add_exec",   OP_R, F_ADD, 1'b0, 1'b1, ST_EXEC,   C_EX_ADD);
    add("add_aluwb",  OP_R, F_ADD, 1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
    add("sub_fetch",  OP_R, F_SUB, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("sub_decode", OP_R, F_SUB, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("sub_exec",   OP_R, F_SUB, 1'b0, 1'b1, ST_EXEC,   C_EX_SUB);
    add("sub_aluwb",  OP_R, F_SUB, 1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
    add("and_fetch",  OP_R, F_AND, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("and_decode", OP_R, F_AND, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("and_exec",   OP_R, F_AND, 1'b0, 1'b1, ST_EXEC,   C_EX_AND);
    add("and_aluwb",  OP_R, F_AND, 1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
    add("or_fetch",   OP_R, F_OR,  1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("or_decode",  OP_R, F_OR,  1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("or_exec",    OP_R, F_OR,  1'b0, 1'b1, ST_EXEC,   C_EX_OR);
    add("or_aluwb",   OP_R, F_OR,  1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
    add("badf_fetch", OP_R, F_BAD, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("badf_dec",   OP_R, F_BAD, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("badf_exec",  OP_R, F_BAD, 1'b0, 1'b1, ST_EXEC,   C_EX_ILL);
    add("beqt_fetch", OP_BEQ, 6'd0, 1'b1, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("beqt_dec",   OP_BEQ, 6'd0, 1'b1, 1'b1, ST_DECODE, C_DECODE);
    add("beqt_br",    OP_BEQ, 6'd0, 1'b1, 1'b1, ST_BRANCH, C_BR_TAKEN);
    add("beqn_fetch", OP_BEQ, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("beqn_dec",   OP_BEQ, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("beqn_br",    OP_BEQ, 6'd0, 1'b0, 1'b1, ST_BRANCH, C_BR_NOT);
    add("addi_fetch", OP_ADDI, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("addi_dec",   OP_ADDI, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("addi_ex",    OP_ADDI, 6'd0, 1'b0, 1'b1, ST_ADDIEX, C_ADDIEX);
    add("addi_wb",    OP_ADDI, 6'd0, 1'b0, 1'b1, ST_ADDIWB, C_ADDIWB);
    add("j_fetch",    OP_J, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("j_decode",   OP_J, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("j_jump",     OP_J, 6'd0, 1'b0, 1'b1, ST_JUMP,   C_JUMP);
    add("bad_fetch",  OP_BAD, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("bad_decode", OP_BAD, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE_ILL);
    add("lws_fetch",  OP_LW, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    add("lws_decode", OP_LW, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    add("lws_memadr", OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMADR, C_MEMADR);
    add("lws_wait1",  OP_LW, 6'd0, 1'b0, 1'b0, ST_MEMRD,  C_MEMRD);
    add("lws_wait2",  OP_LW, 6'd0, 1'b0, 1'b0, ST_MEMRD,  C_MEMRD);
    add("lws_done",   OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMRD,  C_MEMRD);
    add("lws_memwb",  OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMWB,  C_MEMWB);
    add("end_fetch",  OP_R, F_ADD, 1'b0, 1'b0, ST_FETCH,  C_FETCH_WAIT);

    // Reset held with mem_ready high: FETCH must still drive all-zero controls.
    reset = 1'b1;
    drive(OP_LW, F_ADD, 1'b1, 1'b1);
    #1;
    check("reset_state", ST_FETCH, C_ZERO);
    @(negedge clk);
    check("reset_held", ST_FETCH, C_ZERO);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset between edges while in MEMWB: regwrite must drop at once.
    step("r1_fetch",  OP_LW, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    step("r1_decode", OP_LW, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    step("r1_memadr", OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMADR, C_MEMADR);
    step("r1_memrd",  OP_LW, 6'd0, 1'b0, 1'b1, ST_MEMRD,  C_MEMRD);
    #1;
    check("r1_memwb", ST_MEMWB, C_MEMWB);
    #1 reset = 1'b1;
    #1;
    check("r1_async_rst", ST_FETCH, C_ZERO);
    @(negedge clk);
    check("r1_rst_edge", ST_FETCH, C_ZERO);
    reset = 1'b0;
    step("r1_restart", OP_SW, 6'd0, 1'b0, 1'b1, ST_FETCH, C_FETCH_RDY);

    // Reset while a store is stalled: memwrite must drop with no edge.
    step("r2_decode", OP_SW, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    step("r2_memadr", OP_SW, 6'd0, 1'b0, 1'b1, ST_MEMADR, C_MEMADR);
    drive(OP_SW, 6'd0, 1'b0, 1'b0);
    #1;
    check("r2_memwr", ST_MEMWR, C_MEMWR);
    #1 reset = 1'b1;
    #1;
    check("r2_async_rst", ST_FETCH, C_ZERO);
    @(negedge clk);
    reset = 1'b0;
    step("r2_fwait",  OP_J, 6'd0, 1'b0, 1'b0, ST_FETCH,  C_FETCH_WAIT);
    step("r2_fetch",  OP_J, 6'd0, 1'b0, 1'b1, ST_FETCH,  C_FETCH_RDY);
    step("r2_decode", OP_J, 6'd0, 1'b0, 1'b1, ST_DECODE, C_DECODE);
    step("r2_jump",   OP_J, 6'd0, 1'b0, 1'b1, ST_JUMP,   C_JUMP);
    step("r2_final",  OP_J, 6'd0, 1'b0, 1'b0, ST_FETCH,  C_FETCH_WAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
